board_render_sched: RTL

BOARD_RENDER_SCHED -- requirements
Module: board_render_sched

---
 rtl/othello_pkg.sv | 47 ++++
 rtl/cell_wait_timer.sv | 39 +++
 rtl/board_render_sched.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/othello_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : othello_pkg
//  Purpose  : Shared definitions for the Othello board renderer. Contains the
//             scheduler state encoding, the cell-plotter select codes and the
//             board-memory cell codes. A helper maps a board cell and a
//             cursor hit to a plotter select code.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package othello_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_FIRE  = 3'd3,
    ST_WAIT  = 3'd4
  } sched_state_t;

  // Cell-plotter select codes
  localparam logic [1:0] SEL_EMPTY  = 2'b00;
  localparam logic [1:0] SEL_CURSOR = 2'b01;
  localparam logic [1:0] SEL_BLACK  = 2'b10;
  localparam logic [1:0] SEL_WHITE  = 2'b11;

  // Board-memory cell codes; 01 is unused and is drawn as empty
  localparam logic [1:0] BRD_EMPTY  = 2'b00;
  localparam logic [1:0] BRD_UNUSED = 2'b01;
  localparam logic [1:0] BRD_BLACK  = 2'b10;
  localparam logic [1:0] BRD_WHITE  = 2'b11;

  // The cursor marker is only shown on an empty square; stones always win.
  function automatic logic [1:0] cell_select(input logic [1:0] brd,
                                             input logic       on_cursor);
    logic [1:0] sel;
    sel = SEL_EMPTY;
    case (brd)
      BRD_BLACK: sel = SEL_BLACK;
      BRD_WHITE: sel = SEL_WHITE;
      default:   sel = on_cursor ? SEL_CURSOR : SEL_EMPTY;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cell_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : cell_wait_timer
//  Purpose  : Loadable down-counter used to hold the scheduler in WAIT while
//             the cell plotter draws. Loading N gives N+1 cycles until and
//             including the first cycle with expired high.
//  Ports    : clock      - rising-edge clock
//             resetn     - asynchronous active-low reset
//             load       - load load_value (priority over counting)
//             load_value - value to load
//             expired    - high while the count is zero
//  Revision : 1.0 - initial release
// ============================================================================
module cell_wait_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule
`default_nettype wire

// File: rtl/board_render_sched.sv
`default_nettype none
// ============================================================================
//  Module   : board_render_sched
//  Purpose  : Schedules cell draws of an 8x8 Othello board onto a cell
//             plotter. Supports a full 64-cell redraw (start) and a
//             single-cell redraw (upd_req/upd_ack). Each cell takes
//             FETCH, LATCH, FIRE and WAIT_CYCLES cycles of WAIT.
//  Ports    : clock, resetn         - clock, async active-low reset
//             start                 - full redraw request pulse
//             upd_req/row/col, ack  - single-cell redraw handshake
//             cur_row, cur_col      - cursor position
//             brd_addr, brd_data    - board memory read port (1-cycle latency)
//             ph_x, ph_y, ph_select - cell origin and select to the plotter
//             ph_enable             - one-cycle draw trigger per cell
//             busy, done            - status and completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module board_render_sched #(
  parameter logic [7:0] X0          = 8'd32,
  parameter logic [6:0] Y0          = 7'd12,
  parameter int         CELL_PX     = 12,
  parameter logic [7:0] WAIT_CYCLES = 8'd152
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       upd_req,
  input  logic [2:0] upd_row,
  input  logic [2:0] upd_col,
  output logic       upd_ack,
  input  logic [2:0] cur_row,
  input  logic [2:0] cur_col,
  output logic [5:0] brd_addr,
  input  logic [1:0] brd_data,
  output logic [7:0] ph_x,
  output logic [6:0] ph_y,
  output logic [1:0] ph_select,
  output logic       ph_enable,
  output logic       busy,
  output logic       done
);

  import othello_pkg::*;

  localparam logic [7:0] PITCH_X = 8'(CELL_PX);
  localparam logic [6:0] PITCH_Y = 7'(CELL_PX);

  sched_state_t state;
  logic [5:0]   cell_idx;
  logic         full_mode;
  logic         restart;
  logic         wait_expired;
  logic         timer_load;
  logic         wait_exit;
  logic         restart_now;
  logic         last_cell;
  logic [2:0]   row;
  logic [2:0]   col;

  assign row = cell_idx[5:3];
  assign col = cell_idx[2:0];

  // A start arriving in the final WAIT cycle counts as a restart too.
  assign restart_now = restart | start;
  assign wait_exit   = (state == ST_WAIT) && wait_expired;
  assign last_cell   = !full_mode || (cell_idx == 6'd63);

  // Ack and done mark the transition cycle itself, so they decode the
  // registered state rather than lagging it by one clock.
  assign upd_ack = (state == ST_IDLE) && upd_req && !start;
  assign done    = wait_exit && !restart_now && last_cell;
  assign busy    = (state != ST_IDLE);

  // Loaded in FIRE with WAIT_CYCLES-1 so WAIT lasts exactly WAIT_CYCLES.
  assign timer_load = (state == ST_FIRE);

  cell_wait_timer #(
    .WIDTH (8)
  ) u_wait_timer (
    .clock      (clock),
    .resetn     (resetn),
    .load       (timer_load),
    .load_value (WAIT_CYCLES - 8'd1),
    .expired    (wait_expired)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cell_idx  <= 6'd0;
      full_mode <= 1'b0;
      restart   <= 1'b0;
      brd_addr  <= 6'd0;
      ph_x      <= 8'd0;
      ph_y      <= 7'd0;
      ph_select <= SEL_EMPTY;
      ph_enable <= 1'b0;
    end else begin
      ph_enable <= 1'b0;

      if (start && (state != ST_IDLE)) begin
        restart <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            full_mode <= 1'b1;
            cell_idx  <= 6'd0;
            brd_addr  <= 6'd0;
            state     <= ST_FETCH;
          end else if (upd_req) begin
            full_mode <= 1'b0;
            cell_idx  <= {upd_row, upd_col};
            brd_addr  <= {upd_row, upd_col};
            state     <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          state <= ST_LATCH;
        end

        ST_LATCH: begin
          ph_x      <= X0 + ({5'd0, col} * PITCH_X);
          ph_y      <= Y0 + ({4'd0, row} * PITCH_Y);
          ph_select <= cell_select(brd_data,
                                   (row == cur_row) && (col == cur_col));
          ph_enable <= 1'b1;
          state     <= ST_FIRE;
        end

        ST_FIRE: begin
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (wait_expired) begin
            restart <= 1'b0;
            if (restart_now) begin
              full_mode <= 1'b1;
              cell_idx  <= 6'd0;
              brd_addr  <= 6'd0;
              state     <= ST_FETCH;
            end else if (!last_cell) begin
              cell_idx  <= cell_idx + 6'd1;
              brd_addr  <= cell_idx + 6'd1;
              state     <= ST_FETCH;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
